ahb_mem_slave: RTL and testbench
================================

// Module: ahb_mem_slave
// PURPOSE
// - AHB responder in front of a single-port synchronous SRAM (instruction or data memory).
// - Receives the transfers issued by the CPU-side bus master wrappers and answers them:
//   - read data, OKAY/ERROR response, wait states on HReady_out.
// - Sits between the AHB decoder/mux (HSel) and the memory macro.
// PARAMETERS
// - ADDR_BITS    14  word-address width into SRAM (depth = 2**ADDR_BITS words)
// - WAIT_STATES   1  HReady_out-low cycles per transfer; legal range 1..7 (SRAM read latency is 1)
// PORTS
// - clk          in   1   clock, all flops rise-edge
// - rst          in   1   asynchronous, active-high reset
// - HSel         in   1   slave select from decoder
// - HAddress     in   32  transfer address (byte address)
// - HTrans       in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
// - HSize        in   3   000 byte, 001 half, 010 word, others illegal
// - HWrite       in   1   1 = write
// - HWrite_data  in   32  write data, valid through the data phase
// - HReady       in   1   bus HREADY (previous transfer completing)
// - HRead_data   out  32  read data, valid when HReady_out=1 in a read data phase
// - HReady_out   out  1   0 = extend data phase
// - HResp        out  2   00 OKAY, 01 ERROR
// - mem_cs       out  1   SRAM chip select
// - mem_we       out  1   SRAM write enable
// - mem_be       out  4   byte enables, active-high, bit i = byte lane i
// - mem_addr     out  ADDR_BITS  SRAM word address
// - mem_wdata    out  32  SRAM write data
// - mem_rdata    in   32  SRAM read data, valid the cycle after mem_cs with mem_we=0
// BEHAVIOUR
// Reset (async): state IDLE, HReady_out=1, HResp=00, HRead_data=0, mem_cs=0, mem_we=0, mem_be=0.
// Address phase:
// - Sampled at a rising edge when HSel && HReady && HTrans[1].
// - Register: HAddress[ADDR_BITS+1:0], HSize, HWrite.
// - Higher address bits are ignored; the memory aliases.
// - IDLE/BUSY, or HSel=0, samples nothing; the response stays OKAY with zero wait.
// Legality: HSize>010, or misalignment, is ERROR.
// - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
// FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
// - IDLE -> WAIT: legal transfer sampled. Load wait counter = WAIT_STATES-1.
// - IDLE -> ERR1: illegal transfer sampled.
// - WAIT: HReady_out=0, HResp=00.
//   - Counter decrements; at 0 -> LAST.
//   - Read: mem_cs=1, mem_we=0 in the final WAIT cycle only.
// - LAST: HReady_out=1, HResp=00.
//   - Read: HRead_data = mem_rdata.
//   - Write: mem_cs=1, mem_we=1, mem_wdata=HWrite_data, mem_be from size/addr.
//   - New transfer sampled this edge -> WAIT/ERR1 (back-to-back, no idle cycle); else -> IDLE.
// - ERR1: HReady_out=0, HResp=01, no memory access -> ERR2.
// - ERR2: HReady_out=1, HResp=01.
//   - A transfer sampled here is processed normally (-> WAIT/ERR1); else -> IDLE.
// Byte lanes (little-endian):
// - byte: mem_be = 1<<addr[1:0]
// - half: mem_be = addr[1] ? 1100 : 0011
// - word: mem_be = 1111
// - Reads always return the full word; the master extracts lanes.
// Outputs outside the above:
// - mem_cs=0, mem_we=0.
// - HRead_data holds its last value; it is don't-care except in read LAST.
// Latency: every legal transfer is WAIT_STATES+1 data-phase cycles; ERROR is always 2 cycles.
// Reset mid-transfer: immediate return to IDLE; a pending write is dropped, with no partial SRAM write.
// TESTING
// - Reset, then idle bus (HTrans=00) -> HReady_out=1, HResp=00, mem_cs=0 every cycle.
// - Word write 0xDEADBEEF @0x0000_0010, WAIT_STATES=1 -> one cycle HReady_out=0, then LAST
//   with mem_we=1, mem_be=1111, mem_addr=4; readback -> HRead_data=0xDEADBEEF.
// - Byte write 0xAA @0x13 over 0x11223344 -> mem_be=1000; word read of 0x10 -> 0xAA223344.
// - Back-to-back NONSEQ read 0x10 then read 0x14 -> second address sampled in first LAST;
//   exactly 2 cycles per transfer, no IDLE between.
// - Word access @0x0000_0002, or HSize=011 -> ERR1 (HReady_out=0, HResp=01), then ERR2
//   (HReady_out=1, HResp=01); mem_cs never asserted.
// - Assert rst in WAIT of a write, WAIT_STATES=3 -> outputs at reset values immediately;
//   SRAM location unchanged.

Source files
------------

// File: rtl/ahb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mem_slave
// Purpose  : AHB responder in front of a single-port synchronous SRAM.
//            Inserts WAIT_STATES wait cycles per legal transfer, returns a
//            two-cycle ERROR for illegal size or misaligned accesses, and
//            drives the SRAM chip select, write enable and byte enables.
// Revision : 1.0  initial release
// ============================================================================
module ahb_mem_slave #(
  parameter int ADDR_BITS   = 14,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 HSel,
  input  logic [31:0]          HAddress,
  input  logic [1:0]           HTrans,
  input  logic [2:0]           HSize,
  input  logic                 HWrite,
  input  logic [31:0]          HWrite_data,
  input  logic                 HReady,
  output logic [31:0]          HRead_data,
  output logic                 HReady_out,
  output logic [1:0]           HResp,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [3:0]           mem_be,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [2:0] CNT_INIT   = 3'(WAIT_STATES - 1);

  state_t               state, state_nxt;
  logic [2:0]           cnt, cnt_nxt;
  logic [ADDR_BITS+1:0] addr_q;
  logic [2:0]           size_q;
  logic                 write_q;
  logic [31:0]          rdata_q;

  logic                 accept_window;
  logic                 sample;
  logic                 legal;
  logic [3:0]           be_calc;

  // Address bits above the SRAM window alias, and HTrans[0] (SEQ vs NONSEQ)
  // does not change how a transfer is served.
  logic unused_bits;
  assign unused_bits = ^{HAddress[31:ADDR_BITS+2], HTrans[0]};

  // A new address phase can only be accepted while the previous data phase
  // is completing (or there is none).
  assign accept_window = (state == ST_IDLE) || (state == ST_LAST) || (state == ST_ERR2);
  assign sample        = HSel && HReady && HTrans[1] && accept_window;

  // Decide legality of the address phase currently on the bus.
  always_comb begin
    legal = 1'b0;
    case (HSize)
      3'b000:  legal = 1'b1;
      3'b001:  legal = (HAddress[0] == 1'b0);
      3'b010:  legal = (HAddress[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Little-endian byte lanes for the registered write transfer.
  always_comb begin
    be_calc = 4'b1111;
    case (size_q)
      3'b000:  be_calc = 4'b0001 << addr_q[1:0];
      3'b001:  be_calc = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be_calc = 4'b1111;
    endcase
  end

  // State, wait counter, captured address phase and read-data hold register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 3'd0;
      addr_q  <= '0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (sample) begin
        addr_q  <= HAddress[ADDR_BITS+1:0];
        size_q  <= HSize;
        write_q <= HWrite;
      end
      if (state == ST_LAST && !write_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Next-state logic and bus/SRAM outputs for the current data phase.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    HReady_out = 1'b1;
    HResp      = RESP_OKAY;
    HRead_data = rdata_q;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;

    case (state)
      ST_IDLE: begin
      end
      ST_WAIT: begin
        HReady_out = 1'b0;
        // SRAM read latency is one cycle, so the read is launched in the
        // final wait cycle and its data lands in LAST.
        if (!write_q && cnt == 3'd0) begin
          mem_cs = 1'b1;
        end
        if (cnt == 3'd0) begin
          state_nxt = ST_LAST;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      ST_LAST: begin
        if (write_q) begin
          mem_cs = 1'b1;
          mem_we = 1'b1;
          mem_be = be_calc;
        end else begin
          HRead_data = mem_rdata;
        end
      end
      ST_ERR1: begin
        HReady_out = 1'b0;
        HResp      = RESP_ERROR;
        state_nxt  = ST_ERR2;
      end
      ST_ERR2: begin
        HResp = RESP_ERROR;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (accept_window) begin
      if (sample) begin
        if (legal) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CNT_INIT;
        end else begin
          state_nxt = ST_ERR1;
        end
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  assign mem_addr  = addr_q[ADDR_BITS+1:2];
  assign mem_wdata = HWrite_data;

endmodule
`default_nettype wire

// File: tb/tb_ahb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_mem_slave
// Purpose  : Randomised and directed bench for ahb_mem_slave with a
//            transfer-level reference model and a behavioural SRAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_ahb_mem_slave;

  localparam int AB    = 6;
  localparam int WS    = 3;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          rst;
  logic          HSel;
  logic [31:0]   HAddress;
  logic [1:0]    HTrans;
  logic [2:0]    HSize;
  logic          HWrite;
  logic [31:0]   HWrite_data;
  logic          HReady;
  logic [31:0]   HRead_data;
  logic          HReady_out;
  logic [1:0]    HResp;
  logic          mem_cs;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AB-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'd0;

  ahb_mem_slave #(.ADDR_BITS(AB), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .HSel(HSel), .HAddress(HAddress), .HTrans(HTrans),
    .HSize(HSize), .HWrite(HWrite), .HWrite_data(HWrite_data), .HReady(HReady),
    .HRead_data(HRead_data), .HReady_out(HReady_out), .HResp(HResp),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM macro: one-cycle read latency, byte-masked writes.
  logic [31:0] sram [DEPTH] = '{default: 32'd0};
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  // Reference model: expected memory contents and expected per-cycle
  // data-phase behaviour, one record per clock cycle.
  typedef struct {
    logic          rdy;
    logic [1:0]    resp;
    logic          cs;
    logic          we;
    logic          rd;
    logic [3:0]    be;
    logic [AB-1:0] addr;
    logic [31:0]   wdata;
  } rec_t;

  logic [31:0] ref_mem [DEPTH] = '{default: 32'd0};
  rec_t        q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_rd;
  logic [3:0]  last_be;
  logic [AB-1:0] last_waddr;

  function automatic rec_t idle_rec();
    rec_t r;
    r.rdy = 1'b1; r.resp = 2'b00; r.cs = 1'b0; r.we = 1'b0; r.rd = 1'b0;
    r.be = 4'b0000; r.addr = '0; r.wdata = 32'd0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Append the data-phase cycles of one accepted transfer.
  task automatic expand(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                        input logic [31:0] wd);
    rec_t r;
    logic ok;
    logic [3:0] be;
    ok = (sz == 3'd0) || (sz == 3'd1 && a[0] == 1'b0) || (sz == 3'd2 && a[1:0] == 2'b00);
    if (!ok) begin
      r = idle_rec(); r.rdy = 1'b0; r.resp = 2'b01; q.push_back(r);
      r = idle_rec(); r.resp = 2'b01; q.push_back(r);
    end else begin
      if (sz == 3'd0)      be = 4'b0001 << a[1:0];
      else if (sz == 3'd1) be = a[1] ? 4'b1100 : 4'b0011;
      else                 be = 4'b1111;
      for (int k = 0; k < WS; k++) begin
        r = idle_rec(); r.rdy = 1'b0; r.addr = a[AB+1:2];
        r.cs = !wr && (k == WS - 1);
        q.push_back(r);
      end
      r = idle_rec(); r.addr = a[AB+1:2]; r.cs = wr; r.we = wr; r.rd = !wr;
      r.be = be; r.wdata = wd;
      q.push_back(r);
    end
  endtask

  // One bus cycle: drive the address phase, check the current data phase,
  // then advance the model across the rising edge.
  task automatic step(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic [2:0] sz, input logic wr, input logic [31:0] wd,
                      input logic stall, output logic acc);
    rec_t cur;
    cur = idle_rec();
    if (q.size() > 0) cur = q[0];
    HSel = sel; HTrans = tr; HAddress = a; HSize = sz; HWrite = wr;
    HWrite_data = cur.we ? cur.wdata : $urandom();
    HReady = cur.rdy && !(stall && q.size() == 0);
    #1;
    chk("hready_out", {31'd0, HReady_out}, {31'd0, cur.rdy});
    chk("hresp", {30'd0, HResp}, {30'd0, cur.resp});
    chk("mem_cs", {31'd0, mem_cs}, {31'd0, cur.cs});
    chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
    if (cur.cs) chk("mem_addr", {26'd0, mem_addr}, {26'd0, cur.addr});
    if (cur.we) begin
      chk("mem_be", {28'd0, mem_be}, {28'd0, cur.be});
      chk("mem_wdata", mem_wdata, cur.wdata);
      last_be = mem_be;
      last_waddr = mem_addr;
    end
    if (cur.rd) begin
      chk("hread_data", HRead_data, ref_mem[cur.addr]);
      last_rd = HRead_data;
    end
    acc = sel && HReady && tr[1];
    @(posedge clk);
    if (q.size() > 0) begin
      if (cur.we)
        for (int i = 0; i < 4; i++)
          if (cur.be[i]) ref_mem[cur.addr][8*i +: 8] = cur.wdata[8*i +: 8];
      void'(q.pop_front());
    end
    if (acc) expand(a, sz, wr, wd);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, $urandom(), 3'd2, 1'b0, 32'd0, 1'b0, acc);
  endtask

  // Hold an address phase until the slave accepts it; n = cycles taken.
  task automatic issue(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                       input logic [31:0] wd, output int n);
    logic acc;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 16) begin
      step(1'b1, 2'b10, a, sz, wr, wd, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      n_checks++; n_errors++;
      $display("FAIL issue_timeout: address %h not accepted within %0d cycles", a, n);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic acc;
    logic sel, wr, stall;
    logic [1:0] tr;
    logic [2:0] sz;
    logic [31:0] a;
    int r;

    rst = 1'b1; HSel = 1'b0; HAddress = 32'd0; HTrans = 2'b00; HSize = 3'd0;
    HWrite = 1'b0; HWrite_data = 32'd0; HReady = 1'b1;
    last_rd = 32'd0; last_be = 4'd0; last_waddr = '0;
    repeat (3) @(negedge clk);
    chk("rst_hready_out", {31'd0, HReady_out}, 32'd1);
    chk("rst_hresp", {30'd0, HResp}, 32'd0);
    chk("rst_hread_data", HRead_data, 32'd0);
    chk("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    rst = 1'b0;
    idle(5);

    // Word write then readback.
    issue(32'h0000_0010, 3'd2, 1'b1, 32'hDEADBEEF, n);
    issue(32'h0000_0010, 3'd2, 1'b0, 32'd0, n);
    chk("wr_word_be", {28'd0, last_be}, 32'h0000_000F);
    chk("wr_word_addr", {26'd0, last_waddr}, 32'd4);
    idle(WS + 2);
    chk("rd_deadbeef", last_rd, 32'hDEADBEEF);

    // Byte merge into an existing word.
    issue(32'h0000_0010, 3'd2, 1'b1, 32'h11223344, n);
    issue(32'h0000_0013, 3'd0, 1'b1, 32'hAA000000, n);
    issue(32'h0000_0010, 3'd2, 1'b0, 32'd0, n);
    chk("wr_byte_be", {28'd0, last_be}, 32'h0000_0008);
    idle(WS + 2);
    chk("rd_byte_merge", last_rd, 32'hAA223344);

    // Back-to-back reads: the second is accepted in the first one's last cycle.
    issue(32'h0000_0014, 3'd2, 1'b1, 32'h5555AAAA, n);
    idle(WS + 2);
    issue(32'h0000_0010, 3'd2, 1'b0, 32'd0, n);
    chk("b2b_first_accept", n, 32'd1);
    issue(32'h0000_0014, 3'd2, 1'b0, 32'd0, n);
    chk("b2b_gap_cycles", n, WS + 1);
    idle(WS + 2);
    chk("b2b_second_data", last_rd, 32'h5555AAAA);

    // Misaligned word, then illegal size.
    issue(32'h0000_0002, 3'd2, 1'b0, 32'd0, n);
    idle(1);
    issue(32'h0000_0000, 3'd3, 1'b1, 32'd0, n);
    idle(3);

    // Randomised traffic with aliasing, errors, stalls from other slaves.
    for (int c = 0; c < 1500; c++) begin
      sel = ($urandom_range(7, 0) != 0);
      r = $urandom_range(9, 0);
      if (r < 6)      tr = {1'b1, 1'($urandom_range(1, 0))};
      else if (r < 8) tr = 2'b00;
      else            tr = 2'b01;
      sz = ($urandom_range(9, 0) < 8) ? 3'($urandom_range(2, 0)) : 3'($urandom_range(7, 3));
      a = $urandom();
      if ($urandom_range(1, 0) == 1) begin
        if (sz == 3'd1) a[0] = 1'b0;
        if (sz == 3'd2) a[1:0] = 2'b00;
      end
      wr = 1'($urandom_range(1, 0));
      stall = ($urandom_range(6, 0) == 0);
      step(sel, tr, a, sz, wr, $urandom(), stall, acc);
    end
    idle(WS + 3);

    // Reset while a write is waiting: nothing may reach the SRAM.
    issue(32'h0000_0020, 3'd2, 1'b1, 32'h12345678, n);
    idle(1);
    rst = 1'b1;
    #1;
    chk("midrst_hready_out", {31'd0, HReady_out}, 32'd1);
    chk("midrst_hresp", {30'd0, HResp}, 32'd0);
    chk("midrst_hread_data", HRead_data, 32'd0);
    chk("midrst_mem_cs", {31'd0, mem_cs}, 32'd0);
    chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("midrst_mem_be", {28'd0, mem_be}, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(WS + 3);

    for (int i = 0; i < DEPTH; i++) chk($sformatf("sram_word_%0d", i), sram[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
